// File: rtl/mux_sel_pkg.sv
// Shared encodings for the 3-source arbiter and its downstream 3:1 mux.
// Holds sel codes, the arbiter state enum, the source index type and helpers.
package mux_sel_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A    = 2'b00;
  localparam sel_t SEL_B    = 2'b01;
  localparam sel_t SEL_C    = 2'b10;
  localparam sel_t SEL_NONE = 2'b11;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  typedef logic [1:0] src_t;

  localparam src_t SRC_A = 2'd0;
  localparam src_t SRC_B = 2'd1;
  localparam src_t SRC_C = 2'd2;

  // Next source in rotation; the unused code folds back to a.
  function automatic src_t rr_next(src_t s);
    src_t n;
    unique case (s)
      SRC_A:   n = SRC_B;
      SRC_B:   n = SRC_C;
      default: n = SRC_A;
    endcase
    return n;
  endfunction

  function automatic sel_t sel_of(src_t s);
    sel_t r;
    unique case (s)
      SRC_A:   r = SEL_A;
      SRC_B:   r = SEL_B;
      SRC_C:   r = SEL_C;
      default: r = SEL_NONE;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] onehot_of(src_t s);
    logic [2:0] r;
    unique case (s)
      SRC_A:   r = 3'b001;
      SRC_B:   r = 3'b010;
      SRC_C:   r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mux3_rr_arbiter_rr_pick3.sv
// rr_pick3: combinational rotating pick over three requesters.
// Ports: req[2:0], last (previous winner) -> valid, index (winner).
module rr_pick3
  import mux_sel_pkg::*;
(
  input  logic [2:0] req,
  input  src_t       last,
  output logic       valid,
  output src_t       index
);

  logic [3:0] req4;
  src_t       first;
  src_t       second;

  // Padding keeps the select in range for the unused index code.
  assign req4   = {1'b0, req};
  assign first  = rr_next(last);
  assign second = rr_next(first);
  assign valid  = |req;

  // Scan last+1, last+2, then last itself.
  always_comb begin
    index = last;
    priority case (1'b1)
      req4[first]:  index = first;
      req4[second]: index = second;
      default:      index = last;
    endcase
  end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter driving the select of a downstream 3:1 mux.
// Ports: clk, rst (sync, active high), req[2:0], done -> sel[1:0],
// grant[2:0] (one-hot or 0), busy, timeout (pulse on forced release).
// Optional hold limit: define MUX3_RR_ARBITER_TIMEOUT_EN.
module mux3_rr_arbiter
  import mux_sel_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [2:0] grant,
  output logic       busy,
  output logic       timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD out of range 1..255");
  end

  state_t     state;
  src_t       last;
  logic [3:0] req4;
  logic       owner_req;
  logic       rel_req;
  logic       pick_valid;
  src_t       pick_idx;
  logic       limit_hit;

  rr_pick3 u_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // In GRANT, last always names the current owner.
  assign req4      = {1'b0, req};
  assign owner_req = req4[last];
  assign rel_req   = done | ~owner_req;

`ifdef MUX3_RR_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] hold_cnt;

  // hold_cnt = cycles already shown minus one; the limit
  // fires on the cycle the owner completes MAX_HOLD cycles.
  assign limit_hit = (hold_cnt == CW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + CW'(1);
    end
  end

  // A normal release in the limit cycle wins over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout <= 1'b0;
    end else begin
      timeout <= (state == GRANT) & ~rel_req & limit_hit;
    end
  end
`else
  assign limit_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= SRC_C;
      sel   <= SEL_NONE;
      grant <= 3'b000;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= GRANT;
            last  <= pick_idx;
            sel   <= sel_of(pick_idx);
            grant <= onehot_of(pick_idx);
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          // last is kept so the others are scanned first next time.
          if (rel_req | limit_hit) begin
            state <= IDLE;
            sel   <= SEL_NONE;
            grant <= 3'b000;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Self-checking bench for mux3_rr_arbiter: scoreboard of expected outputs,
// directed scenarios, random traffic with invariant and mux checks.
module tb_mux3_rr_arbiter;
  import mux_sel_pkg::*;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       done;
  logic [1:0] sel;
  logic [2:0] grant;
  logic       busy;
  logic       timeout;

  logic [7:0] da, db, dc;
  logic [2:0] prev_g;

  mux3_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [2:0] grant;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  bit m_busy;
  int m_last;
  int m_cnt;

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] mux3(sel_t s, logic [7:0] a,
                                      logic [7:0] b, logic [7:0] c);
    logic [7:0] r;
    case (s)
      SEL_A:   r = a;
      SEL_B:   r = b;
      SEL_C:   r = c;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Reference: computes the outputs expected after the next edge.
  task automatic model(logic r, logic [2:0] q, logic d);
    exp_t e;
    int   win;
    bit   found;
    e = '{sel: 2'b11, grant: 3'b000, busy: 1'b0, to: 1'b0};
    if (r) begin
      m_busy = 0;
      m_last = 2;
      m_cnt  = 0;
    end else if (!m_busy) begin
      found = 0;
      win   = 0;
      for (int k = 1; k <= 3; k++) begin
        if (!found && q[(m_last + k) % 3]) begin
          found = 1;
          win   = (m_last + k) % 3;
        end
      end
      if (found) begin
        m_busy  = 1;
        m_last  = win;
        m_cnt   = 0;
        e.sel   = 2'(win);
        e.grant = 3'(1 << win);
        e.busy  = 1'b1;
      end
    end else if (d || !q[m_last]) begin
      m_busy = 0;
    end else begin
`ifdef MUX3_RR_ARBITER_TIMEOUT_EN
      if (m_cnt == MAXH - 1) begin
        m_busy = 0;
        e.to   = 1'b1;
      end else begin
        m_cnt++;
`else
      begin
`endif
        e.sel   = 2'(m_last);
        e.grant = 3'(1 << m_last);
        e.busy  = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic step(logic r, logic [2:0] q, logic d);
    exp_t       e;
    logic [2:0] c;
    logic [7:0] want_mux;
    rst  = r;
    req  = q;
    done = d;
    da   = 8'($urandom);
    db   = 8'($urandom);
    dc   = 8'($urandom);
    model(r, q, d);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("sb", {sel, grant, busy, timeout}, e);
    end
    c = {grant == 3'b000, sel == SEL_NONE, !busy};
    check("consist", 32'(c == 3'b000 || c == 3'b111), 1);
    check("onehot", 32'($countones(grant) <= 1), 1);
    check("b2b", 32'(!(prev_g != 0 && grant != 0 && grant != prev_g)), 1);
    case (grant)
      3'b001:  want_mux = da;
      3'b010:  want_mux = db;
      3'b100:  want_mux = dc;
      default: want_mux = 8'h00;
    endcase
    check("mux", mux3(sel, da, db, dc), want_mux);
    prev_g = grant;
  endtask

  logic [2:0] order [3];

  initial begin
    rst    = 1'b1;
    req    = 3'b000;
    done   = 1'b0;
    prev_g = 3'b000;
    order  = '{3'b001, 3'b010, 3'b100};

    step(1, 0, 0);
    step(1, 0, 0);
    check("rst_sel", sel, SEL_NONE);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_to", timeout, 0);

    step(0, 3'b001, 0);
    check("a_sel", sel, SEL_A);
    check("a_grant", grant, 3'b001);
    check("a_busy", busy, 1);
    step(0, 3'b001, 1);
    check("a_rel_sel", sel, SEL_NONE);
    check("a_rel_grant", grant, 0);
    step(0, 3'b000, 1);
    check("done_idle", grant, 0);

    step(1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 3'b111, 0);
      check("fair_grant", grant, order[i % 3]);
      step(0, 3'b111, 1);
      check("fair_gap", grant, 0);
    end

    step(1, 0, 0);
    step(0, 3'b010, 0);
    check("drop_b", grant, 3'b010);
    step(0, 3'b000, 0);
    check("drop_idle", busy, 0);
    step(0, 3'b011, 0);
    check("drop_next", grant, 3'b001);
    step(0, 3'b011, 0);
    check("drop_hold", grant, 3'b001);
    step(0, 3'b011, 1);

    step(1, 0, 0);
    step(0, 3'b100, 0);
    check("to_first", grant, 3'b100);
`ifdef MUX3_RR_ARBITER_TIMEOUT_EN
    for (int i = 0; i < MAXH - 1; i++) begin
      step(0, 3'b100, 0);
      check("to_hold", grant, 3'b100);
    end
    step(0, 3'b100, 0);
    check("to_rel", grant, 0);
    check("to_pulse", timeout, 1);
    step(0, 3'b100, 0);
    check("to_regrant", grant, 3'b100);
    check("to_one", timeout, 0);
    for (int i = 0; i < MAXH - 1; i++) step(0, 3'b100, 0);
    step(0, 3'b100, 1);
    check("to_done_rel", grant, 0);
    check("to_done_nopulse", timeout, 0);
`else
    for (int i = 0; i < 100; i++) step(0, 3'b100, 0);
    check("nto_hold", grant, 3'b100);
    check("nto_zero", timeout, 0);
`endif

    step(1, 0, 0);
    step(0, 3'b100, 0);
    check("mid_c", grant, 3'b100);
    step(1, 3'b100, 0);
    check("mid_sel", sel, SEL_NONE);
    check("mid_to", timeout, 0);
    step(0, 3'b111, 0);
    check("mid_after", grant, 3'b001);

    for (int i = 0; i < 2000; i++) begin
      step(logic'($urandom_range(0, 199) == 0),
           3'($urandom),
           logic'($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
